// File: rtl/mult_pkg.sv
// Shared types for the multiplier stream feeder: default operand width,
// feeder FSM states and the operand-pair record stored in the FIFO.
package mult_pkg;

    localparam int MULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } feeder_state_t;

    typedef struct packed {
        logic [MULT_WIDTH-1:0] a;
        logic [MULT_WIDTH-1:0] b;
    } op_pair_t;

endpackage

// File: rtl/mult_stream_feeder_if.sv
// Bundle of the three feeder streams: operand input, multiplier start/done
// side and result output. The feeder takes the slave view, its environment
// takes the master view.
interface mult_stream_feeder_if
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int DEPTH = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH-1:0]         in_a;
    logic [WIDTH-1:0]         in_b;
    logic                     mul_start;
    logic [WIDTH-1:0]         mul_a;
    logic [WIDTH-1:0]         mul_b;
    logic [2*WIDTH-1:0]       mul_product;
    logic                     mul_done;
    logic                     out_valid;
    logic                     out_ready;
    logic [2*WIDTH-1:0]       out_product;
    logic [$clog2(DEPTH):0]   count;

    modport slave (
        input  in_valid, in_a, in_b, mul_product, mul_done, out_ready,
        output in_ready, mul_start, mul_a, mul_b, out_valid, out_product, count
    );

    modport master (
        output in_valid, in_a, in_b, mul_product, mul_done, out_ready,
        input  in_ready, mul_start, mul_a, mul_b, out_valid, out_product, count
    );
endinterface

// File: rtl/mult_op_fifo.sv
// Small synchronous FIFO for operand pairs. Head entry is visible
// combinationally so a pushed entry can be popped on the following cycle.
// Pops never free space for a push in the same cycle (no pass-through).
module mult_op_fifo
    import mult_pkg::*;
#(
    parameter type T     = op_pair_t,
    parameter int  DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  T                       wr_data,
    input  logic                   pop,
    output T                       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    T                mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [AW:0]     count_reg;
    logic            push_ok;
    logic            pop_ok;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr_reg];
    assign count   = count_reg;

    // Storage write; contents need no reset since occupancy guards reads.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; occupancy tracks both ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: rtl/mult_stream_feeder.sv
// Valid/ready front-end for a start/done sequential multiplier. Operands are
// queued, issued one at a time, and each product is held in an output
// register until the consumer takes it.
module mult_stream_feeder
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    mult_stream_feeder_if.slave bus
);
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } pair_t;

    pair_t                   wr_pair;
    pair_t                   head_pair;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic                    pop;
    logic                    out_free;

    feeder_state_t           state_reg;
    logic                    armed_reg;
    logic                    mul_start_reg;
    logic [WIDTH-1:0]        mul_a_reg;
    logic [WIDTH-1:0]        mul_b_reg;
    logic                    out_valid_reg;
    logic [2*WIDTH-1:0]      out_product_reg;

    assign wr_pair  = '{a: bus.in_a, b: bus.in_b};
    // Issue only when the output register is guaranteed free by the time
    // the product arrives, so a capture never overwrites an unaccepted result.
    assign out_free = !out_valid_reg || bus.out_ready;
    assign pop      = (state_reg == IDLE) && !fifo_empty && out_free;

    mult_op_fifo #(
        .T     (pair_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push    (bus.in_valid),
        .wr_data (wr_pair),
        .pop     (pop),
        .rd_data (head_pair),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign bus.in_ready    = !fifo_full;
    assign bus.count       = fifo_count;
    assign bus.mul_start   = mul_start_reg;
    assign bus.mul_a       = mul_a_reg;
    assign bus.mul_b       = mul_b_reg;
    assign bus.out_valid   = out_valid_reg;
    assign bus.out_product = out_product_reg;

    // Issue FSM plus output register. The armed flag ignores a done level
    // left high by the previous multiply until done has been seen low once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IDLE;
            armed_reg       <= 1'b0;
            mul_start_reg   <= 1'b0;
            mul_a_reg       <= '0;
            mul_b_reg       <= '0;
            out_valid_reg   <= 1'b0;
            out_product_reg <= '0;
        end else begin
            mul_start_reg <= 1'b0;
            if (out_valid_reg && bus.out_ready) begin
                out_valid_reg <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        mul_a_reg     <= head_pair.a;
                        mul_b_reg     <= head_pair.b;
                        armed_reg     <= 1'b0;
                        mul_start_reg <= 1'b1;
                        state_reg     <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_reg <= WAIT;
                end
                WAIT: begin
                    if (!bus.mul_done) begin
                        armed_reg <= 1'b1;
                    end
                    if (bus.mul_done && armed_reg) begin
                        out_product_reg <= bus.mul_product;
                        out_valid_reg   <= 1'b1;
                        state_reg       <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_stream_feeder.sv
// Self-checking bench for mult_stream_feeder: multiplier model with
// configurable latency and done style, operand/result scoreboards, vector
// tables and hand-written corner-case sequences.
module tb_mult_stream_feeder;
    import mult_pkg::*;

    localparam int W = 16;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_stream_feeder_if #(.WIDTH(W), .DEPTH(D)) bus();

    mult_stream_feeder #(.WIDTH(W), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event did not occur within its bound", name);
    endtask

    // Multiplier model: product appears lat cycles after the sampled start.
    // mode 0 = level done cleared on start, 1 = one-cycle pulse,
    // 2 = level done cleared one cycle after start (stale-done case).
    int          lat       = 17;
    int          done_mode = 0;
    bit          stall     = 1'b0;
    int          cnt       = 0;
    logic        drop_late = 1'b0;
    logic [31:0] pend      = 32'h0;
    logic        md_done   = 1'b0;
    logic [31:0] md_prod   = 32'h0;

    assign bus.mul_done    = md_done;
    assign bus.mul_product = md_prod;

    always @(posedge clk) begin
        if (done_mode == 1) md_done <= 1'b0;
        if (drop_late) begin
            md_done   <= 1'b0;
            drop_late <= 1'b0;
        end
        if (bus.mul_start) begin
            cnt  <= lat;
            pend <= {16'h0, bus.mul_a} * {16'h0, bus.mul_b};
            if (done_mode == 0) md_done <= 1'b0;
            if (done_mode == 2) drop_late <= 1'b1;
        end else if (cnt != 0 && !stall) begin
            cnt <= cnt - 1;
            if (cnt == 1) begin
                md_done <= 1'b1;
                md_prod <= pend;
            end
        end
    end

    // Scoreboards fed on the negative edge, where handshakes are stable.
    op_pair_t    op_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    op_pair_t    mon_op;
    int          starts    = 0;
    int          outs      = 0;
    int          max_count = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (bus.in_valid && bus.in_ready) begin
                mon_op.a = bus.in_a;
                mon_op.b = bus.in_b;
                op_q.push_back(mon_op);
                exp_q.push_back({16'h0, bus.in_a} * {16'h0, bus.in_b});
            end
            if (bus.mul_start) begin
                starts++;
                if (op_q.size() == 0) begin
                    fail_now("unexpected mul_start");
                end else begin
                    mon_op = op_q.pop_front();
                    check("issued mul_a", 64'(bus.mul_a), 64'(mon_op.a));
                    check("issued mul_b", 64'(bus.mul_b), 64'(mon_op.b));
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                outs++;
                got_q.push_back(bus.out_product);
                if (exp_q.size() == 0) begin
                    fail_now("unexpected result");
                end else begin
                    check("result order/value", 64'(bus.out_product), 64'(exp_q.pop_front()));
                end
            end
            if (int'(bus.count) > max_count) max_count = int'(bus.count);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        while (!bus.in_ready && n < 300) begin
            tick();
            n++;
        end
        if (!bus.in_ready) fail_now("push accept");
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 1000) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0 || bus.out_valid) fail_now(name);
    endtask

    task automatic wait_out_valid(input string name);
        int n = 0;
        while (!bus.out_valid && n < 200) begin
            tick();
            n++;
        end
        if (!bus.out_valid) fail_now(name);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t t3_tbl[4];
    vec_t t6_tbl[4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int o0;
        int n;
        logic [31:0] held;
        bit stable;

        t3_tbl[0] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
        t3_tbl[1] = '{16'd2,    16'd7,    32'd14};
        t3_tbl[2] = '{16'd0,    16'd9,    32'd0};
        t3_tbl[3] = '{16'd100,  16'd100,  32'd10000};
        t6_tbl[0] = '{16'd1234, 16'd5678, 32'd7006652};
        t6_tbl[1] = '{16'hFFFF, 16'd1,    32'h0000FFFF};
        t6_tbl[2] = '{16'd0,    16'd0,    32'd0};
        t6_tbl[3] = '{16'h8000, 16'd2,    32'h00010000};

        // Reset values while reset is held.
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        check("reset in_ready",    64'(bus.in_ready),    64'(1));
        check("reset count",       64'(bus.count),       64'(0));
        check("reset mul_start",   64'(bus.mul_start),   64'(0));
        check("reset mul_a",       64'(bus.mul_a),       64'(0));
        check("reset mul_b",       64'(bus.mul_b),       64'(0));
        check("reset out_valid",   64'(bus.out_valid),   64'(0));
        check("reset out_product", 64'(bus.out_product), 64'(0));
        rst = 1'b1;
        tick();

        // Single op: start pulse two cycles after the push cycle, result for one cycle.
        lat = 17; done_mode = 0;
        s0 = starts;
        bus.in_valid = 1'b1; bus.in_a = 16'd3; bus.in_b = 16'd5;
        tick();
        bus.in_valid = 1'b0;
        check("single count after push", 64'(bus.count), 64'(1));
        check("single start cycle1", 64'(bus.mul_start), 64'(0));
        tick();
        check("single start cycle2", 64'(bus.mul_start), 64'(1));
        tick();
        check("single start width",  64'(bus.mul_start), 64'(0));
        wait_out_valid("single out_valid");
        check("single product", 64'(bus.out_product), 64'(15));
        tick();
        check("single out_valid one cycle", 64'(bus.out_valid), 64'(0));
        check("single start pulses", 64'(starts - s0), 64'(1));

        // Back-to-back pushes from the table.
        got_q.delete();
        s0 = starts;
        max_count = 0;
        for (int i = 0; i < 4; i++) begin
            push(t3_tbl[i].a, t3_tbl[i].b);
            if (i == 1) check("push+pop count unchanged", 64'(bus.count), 64'(1));
        end
        wait_drain("b2b drain");
        check("b2b result count", 64'(got_q.size()), 64'(4));
        for (int i = 0; i < 4; i++) begin
            if (i < got_q.size()) check($sformatf("b2b vec%0d", i), 64'(got_q[i]), 64'(t3_tbl[i].exp));
        end
        check("b2b start pulses", 64'(starts - s0), 64'(4));
        check("b2b count peak",   64'(max_count),   64'(3));

        // Fill past full with the multiplier stalled.
        lat = 5; stall = 1'b1;
        s0 = starts; o0 = outs; max_count = 0;
        push(16'd1, 16'd1);
        push(16'd2, 16'd3);
        push(16'd4, 16'd5);
        push(16'd6, 16'd7);
        push(16'd8, 16'd9);
        check("full count",    64'(bus.count),    64'(4));
        check("full in_ready", 64'(bus.in_ready), 64'(0));
        bus.in_valid = 1'b1; bus.in_a = 16'd10; bus.in_b = 16'd11;
        tick(); tick(); tick();
        check("5th not accepted count", 64'(bus.count),    64'(4));
        check("5th not accepted ready", 64'(bus.in_ready), 64'(0));
        stall = 1'b0;
        push(16'd10, 16'd11);
        check("refill count", 64'(bus.count), 64'(4));
        wait_drain("full drain");
        check("full count peak",   64'(max_count),   64'(4));
        check("full start pulses", 64'(starts - s0), 64'(6));
        check("full results",      64'(outs - o0),   64'(6));

        // Backpressure: first result held, second op not issued meanwhile.
        lat = 5;
        bus.out_ready = 1'b0;
        s0 = starts; o0 = outs;
        push(16'd11, 16'd13);
        push(16'd17, 16'd19);
        wait_out_valid("bp first result");
        held = bus.out_product;
        check("bp first product", 64'(held), 64'(143));
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (!bus.out_valid || bus.out_product !== held) stable = 1'b0;
        end
        check("bp held stable",      64'(stable),      64'(1));
        check("bp second not issued", 64'(starts - s0), 64'(1));
        bus.out_ready = 1'b1;
        wait_drain("bp drain");
        check("bp start pulses", 64'(starts - s0), 64'(2));
        check("bp results",      64'(outs - o0),   64'(2));

        // Done styles: level, pulse, and level released late after start.
        for (int m = 0; m < 3; m++) begin
            done_mode = m;
            lat = (m == 2) ? 4 : ((m == 1) ? 3 : 2);
            got_q.delete();
            o0 = outs;
            for (int i = 0; i < 4; i++) push(t6_tbl[i].a, t6_tbl[i].b);
            wait_drain("done style drain");
            n = 0;
            while (n < 30) begin
                tick();
                n++;
            end
            check($sformatf("done mode%0d results", m), 64'(outs - o0), 64'(4));
            for (int i = 0; i < 4; i++) begin
                if (i < got_q.size()) check($sformatf("done mode%0d vec%0d", m, i), 64'(got_q[i]), 64'(t6_tbl[i].exp));
            end
        end

        // Reset during WAIT abandons the in-flight multiply.
        done_mode = 0; lat = 17;
        s0 = starts;
        push(16'd9, 16'd9);
        push(16'd2, 16'd2);
        push(16'd3, 16'd3);
        push(16'd4, 16'd4);
        n = 0;
        while (starts == s0 && n < 20) begin
            tick();
            n++;
        end
        if (starts == s0) fail_now("reset test issue");
        tick(); tick(); tick();
        check("pre-reset out_valid", 64'(bus.out_valid), 64'(0));
        check("pre-reset count",     64'(bus.count),     64'(3));
        #2;
        rst = 1'b0;
        #1;
        check("async reset out_valid", 64'(bus.out_valid), 64'(0));
        check("async reset count",     64'(bus.count),     64'(0));
        check("async reset mul_start", 64'(bus.mul_start), 64'(0));
        check("async reset in_ready",  64'(bus.in_ready),  64'(1));
        op_q.delete();
        exp_q.delete();
        tick();
        rst = 1'b1;
        got_q.delete();
        push(16'd6, 16'd7);
        wait_drain("post-reset drain");
        check("post-reset results", 64'(got_q.size()), 64'(1));
        if (got_q.size() > 0) check("post-reset product", 64'(got_q[0]), 64'(42));
        n = 0;
        while (n < 30) begin
            tick();
            n++;
        end
        check("abandoned result never captured", 64'(got_q.size()), 64'(1));

        check("operand queue empty", 64'(op_q.size()),  64'(0));
        check("result queue empty",  64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
